// File: rtl/prf_wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs drained round-robin onto NUM_WR registered PRF write ports.
// Optional PRF_WB_ARB_PERF_EN adds a saturating perf_conflict_cnt output.
module prf_wb_arbiter #(
  parameter int NUM_EX = 4,
  parameter int NUM_WR = 2,
  parameter int DEPTH  = 2,
  parameter int PREG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [NUM_EX-1:0]          ex_valid,
  output logic [NUM_EX-1:0]          ex_ready,
  input  logic [NUM_EX*32-1:0]       ex_dst_val,
  input  logic [NUM_EX*PREG_W-1:0]   ex_dst_index,
  output logic [NUM_WR-1:0]          wr_valid,
  output logic [NUM_WR*32-1:0]       wr_val,
  output logic [NUM_WR*PREG_W-1:0]   wr_index
`ifdef PRF_WB_ARB_PERF_EN
  ,
  output logic [31:0]                perf_conflict_cnt
`endif
);

  localparam int UNIT_W = (NUM_EX > 1) ? $clog2(NUM_EX) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);

  logic [31:0]       mem_val [NUM_EX][DEPTH];
  logic [PREG_W-1:0] mem_idx [NUM_EX][DEPTH];
  logic [AW-1:0]     rd_ptr  [NUM_EX];
  logic [AW-1:0]     wr_ptr  [NUM_EX];
  logic [CW-1:0]     count   [NUM_EX];
  logic [UNIT_W-1:0] rr_ptr;
  logic [UNIT_W-1:0] rr_next;
  logic [NUM_EX-1:0] push;
  logic [NUM_EX-1:0] grant;
  logic [NUM_EX-1:0] nonempty;
  logic [NUM_WR-1:0] port_valid;
  logic [31:0]       port_val [NUM_WR];
  logic [PREG_W-1:0] port_idx [NUM_WR];

  // Ready looks only at the registered count; preg 0 writes complete the handshake without a push.
  always_comb begin
    for (int i = 0; i < NUM_EX; i++) begin
      ex_ready[i] = (count[i] < CW'(DEPTH)) && rst_n && !flush;
      nonempty[i] = (count[i] != '0);
      push[i]     = ex_valid[i] && ex_ready[i] &&
                    (ex_dst_index[i*PREG_W +: PREG_W] != '0);
    end
  end

  always_comb begin
    int u;
    int n;
    u          = 0;
    n          = 0;
    grant      = '0;
    port_valid = '0;
    rr_next    = rr_ptr;
    for (int k = 0; k < NUM_WR; k++) begin
      port_val[k] = '0;
      port_idx[k] = '0;
    end
    for (int o = 0; o < NUM_EX; o++) begin
      u = int'(rr_ptr) + o;
      if (u >= NUM_EX) u = u - NUM_EX;
      if (nonempty[u] && (n < NUM_WR)) begin
        grant[u]      = 1'b1;
        port_valid[n] = 1'b1;
        port_val[n]   = mem_val[u][rd_ptr[u]];
        port_idx[n]   = mem_idx[u][rd_ptr[u]];
        rr_next       = (u == NUM_EX - 1) ? '0 : UNIT_W'(u + 1);
        n             = n + 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EX; i++) begin
      if (push[i]) begin
        mem_val[i][wr_ptr[i]] <= ex_dst_val[i*32 +: 32];
        mem_idx[i][wr_ptr[i]] <= ex_dst_index[i*PREG_W +: PREG_W];
      end
    end
  end

  // Flush empties the FIFOs and kills the next write cycle but keeps rr_ptr and the held write data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_EX; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr   <= '0;
      wr_valid <= '0;
      wr_val   <= '0;
      wr_index <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_EX; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      wr_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_EX; i++) begin
        if (push[i])  wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (grant[i]) rd_ptr[i] <= rd_ptr[i] + AW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(grant[i]);
      end
      rr_ptr   <= rr_next;
      wr_valid <= port_valid;
      for (int k = 0; k < NUM_WR; k++) begin
        if (port_valid[k]) begin
          wr_val[k*32 +: 32]         <= port_val[k];
          wr_index[k*PREG_W +: PREG_W] <= port_idx[k];
        end
      end
    end
  end

`ifdef PRF_WB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_conflict_cnt <= '0;
    end else if ((|(nonempty & ~grant)) && (perf_conflict_cnt != '1)) begin
      perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Testbench for prf_wb_arbiter: directed scenarios then random traffic, checked against a queue model.
// Honours PRF_WB_ARB_PERF_EN when defined.
module tb_prf_wb_arbiter;

  localparam int NUM_EX = 4;
  localparam int NUM_WR = 2;
  localparam int DEPTH  = 2;
  localparam int PREG_W = 6;
  localparam int ENT_W  = PREG_W + 32;

  typedef logic [ENT_W-1:0] ent_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic [NUM_EX-1:0]        ex_valid;
  logic [NUM_EX-1:0]        ex_ready;
  logic [NUM_EX*32-1:0]     ex_dst_val;
  logic [NUM_EX*PREG_W-1:0] ex_dst_index;
  logic [NUM_WR-1:0]        wr_valid;
  logic [NUM_WR*32-1:0]     wr_val;
  logic [NUM_WR*PREG_W-1:0] wr_index;
`ifdef PRF_WB_ARB_PERF_EN
  logic [31:0]              perf_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ent_t                     mq [NUM_EX][$];
  int                       rr;
  logic [NUM_WR-1:0]        exp_valid;
  logic [NUM_WR*32-1:0]     exp_val;
  logic [NUM_WR*PREG_W-1:0] exp_idx;

  always #5 clk = ~clk;

  prf_wb_arbiter #(
    .NUM_EX(NUM_EX), .NUM_WR(NUM_WR), .DEPTH(DEPTH), .PREG_W(PREG_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_dst_val(ex_dst_val),
    .ex_dst_index(ex_dst_index),
    .wr_valid(wr_valid),
    .wr_val(wr_val),
    .wr_index(wr_index)
`ifdef PRF_WB_ARB_PERF_EN
    ,
    .perf_conflict_cnt(perf_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of the reference: units scanned from rr, the first NUM_WR non-empty ones pop.
  task automatic modelStep();
    logic [NUM_EX-1:0] rdy;
    for (int i = 0; i < NUM_EX; i++)
      rdy[i] = rst_n && !flush && (mq[i].size() < DEPTH);
    checkOutput("ex_ready", 64'(ex_ready), 64'(rdy));
    if (!rst_n) begin
      for (int i = 0; i < NUM_EX; i++) mq[i].delete();
      rr        = 0;
      exp_valid = '0;
      exp_val   = '0;
      exp_idx   = '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_EX; i++) mq[i].delete();
      exp_valid = '0;
    end else begin
      int n;
      int last;
      ent_t e;
      n         = 0;
      last      = -1;
      exp_valid = '0;
      for (int o = 0; o < NUM_EX; o++) begin
        int u;
        u = (rr + o) % NUM_EX;
        if (mq[u].size() > 0 && n < NUM_WR) begin
          e = mq[u].pop_front();
          exp_valid[n]                = 1'b1;
          exp_val[n*32 +: 32]         = e[31:0];
          exp_idx[n*PREG_W +: PREG_W] = e[ENT_W-1:32];
          n++;
          last = u;
        end
      end
      if (last >= 0) rr = (last + 1) % NUM_EX;
      for (int i = 0; i < NUM_EX; i++)
        if (ex_valid[i] && rdy[i] && ex_dst_index[i*PREG_W +: PREG_W] != '0)
          mq[i].push_back({ex_dst_index[i*PREG_W +: PREG_W], ex_dst_val[i*32 +: 32]});
    end
  endtask

  // Drive one cycle from a negedge, step the model at the edge, compare on the next negedge.
  task automatic applyStimulus(input logic r, input logic f, input logic [NUM_EX-1:0] v,
                               input logic [NUM_EX*32-1:0] vals,
                               input logic [NUM_EX*PREG_W-1:0] idxs);
    rst_n        = r;
    flush        = f;
    ex_valid     = v;
    ex_dst_val   = vals;
    ex_dst_index = idxs;
    #1;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput("wr_valid", 64'(wr_valid), 64'(exp_valid));
    checkOutput("wr_val",   64'(wr_val),   64'(exp_val));
    checkOutput("wr_index", 64'(wr_index), 64'(exp_idx));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b1, 1'b0, '0, '0, '0);
  endtask

  task automatic fillAll(input int n, input int base);
    logic [NUM_EX*32-1:0]     vals;
    logic [NUM_EX*PREG_W-1:0] idxs;
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NUM_EX; i++) begin
        vals[i*32 +: 32]         = 32'(base + i * 256 + c);
        idxs[i*PREG_W +: PREG_W] = PREG_W'(((i * 8 + c) % 63) + 1);
      end
      applyStimulus(1'b1, 1'b0, '1, vals, idxs);
    end
  endtask

  initial begin
    logic [NUM_EX*32-1:0]     vals;
    logic [NUM_EX*PREG_W-1:0] idxs;
    logic [NUM_EX-1:0]        v;
    logic                     r;
    logic                     f;

    rst_n = 1'b0; flush = 1'b0; ex_valid = '0; ex_dst_val = '0; ex_dst_index = '0;
    rr = 0; exp_valid = '0; exp_val = '0; exp_idx = '0;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    checkOutput("reset_wr_valid", 64'(wr_valid), 64'd0);
    checkOutput("reset_wr_index", 64'(wr_index), 64'd0);
    idle(1);

    $display("[TB] single result");
    applyStimulus(1'b1, 1'b0, 4'b0001, {96'd0, 32'hDEADBEEF}, {18'd0, 6'd5});
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    checkOutput("single_valid", 64'(wr_valid), 64'b01);
    checkOutput("single_val0",  64'(wr_val[31:0]), 64'hDEADBEEF);
    checkOutput("single_idx0",  64'(wr_index[PREG_W-1:0]), 64'd5);
    idle(2);

    $display("[TB] full contention");
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 4'b1111,
                  {32'hD0D0_0013, 32'hC0C0_0012, 32'hB0B0_0011, 32'hA0A0_0010},
                  {6'd13, 6'd12, 6'd11, 6'd10});
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    checkOutput("contend_c3_idx", 64'(wr_index), 64'({6'd11, 6'd10}));
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    checkOutput("contend_c4_idx", 64'(wr_index), 64'({6'd13, 6'd12}));
    checkOutput("contend_c4_valid", 64'(wr_valid), 64'b11);
    applyStimulus(1'b1, 1'b0, 4'b0001, {96'd0, 32'h0000_0777}, {18'd0, 6'd20});
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    checkOutput("contend_rr_back_to_0", 64'(wr_valid), 64'b01);
    idle(1);

    $display("[TB] backpressure");
    fillAll(12, 32'h1000);
    idle(4);

    $display("[TB] zero destination");
    applyStimulus(1'b1, 1'b0, 4'b0100, {32'd0, 32'h1234, 64'd0}, '0);
    idle(3);
    checkOutput("zero_dst_none", 64'(wr_valid), 64'd0);

    $display("[TB] flush");
    fillAll(3, 32'h2000);
    applyStimulus(1'b1, 1'b1, '1, '1, '1);
    checkOutput("flush_wr_valid", 64'(wr_valid), 64'd0);
    idle(1);
    checkOutput("flush_ready", 64'(ex_ready), 64'hF);
    idle(3);

    $display("[TB] mid-operation reset");
    fillAll(3, 32'h3000);
    applyStimulus(1'b0, 1'b0, '1, '1, '1);
    checkOutput("midrst_valid", 64'(wr_valid), 64'd0);
    checkOutput("midrst_val",   64'(wr_val),   64'd0);
    checkOutput("midrst_idx",   64'(wr_index), 64'd0);
    checkOutput("midrst_ready", 64'(ex_ready), 64'd0);
`ifdef PRF_WB_ARB_PERF_EN
    checkOutput("perf_after_reset", 64'(perf_cnt), 64'd0);
`endif
    idle(4);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 99) != 0);
      f = ($urandom_range(0, 39) == 0);
      v = NUM_EX'($urandom);
      for (int i = 0; i < NUM_EX; i++) begin
        vals[i*32 +: 32]         = $urandom;
        idxs[i*PREG_W +: PREG_W] = PREG_W'($urandom_range(0, 63));
      end
      applyStimulus(r, f, v, vals, idxs);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
